rtr_next_hop_sched: RTL and testbench

- Per-input-port scheduler that shares one combinational next-hop address unit among all VCs of the port.
- Each VC presents the dest_info/lar_info of a new packet's head flit. The block latches it, round-robin arbitrates VC access to the shared unit, and captures the returned next-router address.
- The captured address is held per VC until the packet's tail flit departs.
- Sits between the input VC controllers and the shared lookahead next-hop logic.

---
 rtl/rtr_next_hop_sched.sv | 206 ++++++++++++++++++++
 tb/tb_rtr_next_hop_sched.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rtr_next_hop_sched.sv
`default_nettype none
// ============================================================================
// Module   : rtr_next_hop_sched
// Brief    : Per-input-port scheduler that lets every VC of the port share one
//            combinational next-hop address unit. Each VC latches the routing
//            info of a new head flit, requests the unit through a round-robin
//            arbiter, captures the returned next-router address and holds it
//            until the tail flit of that packet has left the VC.
// Revision : 1.0 - initial release
// ============================================================================
module rtr_next_hop_sched #(
  parameter int NUM_VCS           = 4,
  parameter int DEST_INFO_WIDTH   = 17,
  parameter int LAR_INFO_WIDTH    = 4,
  parameter int ROUTER_ADDR_WIDTH = 4
) (
  input  logic                                   clk,
  input  logic                                   reset,
  // VC controller side
  input  logic [NUM_VCS-1:0]                     vc_head_valid,
  input  logic [NUM_VCS*DEST_INFO_WIDTH-1:0]     vc_dest_info,
  input  logic [NUM_VCS*LAR_INFO_WIDTH-1:0]      vc_lar_info,
  input  logic [NUM_VCS-1:0]                     vc_tail_done,
  // shared next-hop unit side
  output logic                                   shu_valid,
  output logic [DEST_INFO_WIDTH-1:0]             shu_dest_info,
  output logic [LAR_INFO_WIDTH-1:0]              shu_lar_info,
  input  logic [ROUTER_ADDR_WIDTH-1:0]           shu_next_addr,
  // per-VC route results
  output logic [NUM_VCS-1:0]                     vc_route_valid,
  output logic [NUM_VCS*ROUTER_ADDR_WIDTH-1:0]   vc_next_addr,
  output logic [NUM_VCS-1:0]                     vc_grant,
  output logic                                   err_proto
);

  localparam int PTR_W = (NUM_VCS > 1) ? $clog2(NUM_VCS) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2
  } vc_state_t;

  // Flattened views of the per-VC latched info; slot i holds VC i (LSB-first
  // internally, the MSB-first packing only applies to the ports).
  logic [NUM_VCS*DEST_INFO_WIDTH-1:0] dest_all;
  logic [NUM_VCS*LAR_INFO_WIDTH-1:0]  lar_all;

  logic [NUM_VCS-1:0] req;
  logic [NUM_VCS-1:0] grant;
  logic [NUM_VCS-1:0] err_vec;
  logic [PTR_W-1:0]   rr_ptr;
  logic [PTR_W-1:0]   grant_idx;

  // --------------------------------------------------------------------------
  // Per-VC route FSM and its latched info / captured address
  // --------------------------------------------------------------------------
  for (genvar i = 0; i < NUM_VCS; i++) begin : g_vc
    localparam int DSL = (NUM_VCS - 1 - i) * DEST_INFO_WIDTH;
    localparam int LSL = (NUM_VCS - 1 - i) * LAR_INFO_WIDTH;
    localparam int ASL = (NUM_VCS - 1 - i) * ROUTER_ADDR_WIDTH;

    vc_state_t                    state;
    logic [DEST_INFO_WIDTH-1:0]   dest_q;
    logic [LAR_INFO_WIDTH-1:0]    lar_q;
    logic [ROUTER_ADDR_WIDTH-1:0] addr_q;

    logic                         head;
    logic                         tail;
    logic [DEST_INFO_WIDTH-1:0]   dest_in;
    logic [LAR_INFO_WIDTH-1:0]    lar_in;

    assign head    = vc_head_valid[i];
    assign tail    = vc_tail_done[i];
    assign dest_in = vc_dest_info[DSL +: DEST_INFO_WIDTH];
    assign lar_in  = vc_lar_info[LSL +: LAR_INFO_WIDTH];

    // IDLE -> WAIT on a head, WAIT -> HOLD on grant, HOLD -> IDLE/WAIT on tail
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        state  <= ST_IDLE;
        dest_q <= '0;
        lar_q  <= '0;
        addr_q <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (head) begin
              dest_q <= dest_in;
              lar_q  <= lar_in;
              state  <= ST_WAIT;
            end
          end
          ST_WAIT: begin
            // a head arriving here is a protocol error and is not latched
            if (grant[i]) begin
              addr_q <= shu_next_addr;
              state  <= ST_HOLD;
            end
          end
          ST_HOLD: begin
            if (tail) begin
              if (head) begin
                // back-to-back packet: reload and re-arbitrate, route drops
                dest_q <= dest_in;
                lar_q  <= lar_in;
                state  <= ST_WAIT;
              end else begin
                state  <= ST_IDLE;
              end
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end

    // Protocol checks: head while busy, or tail with no route held
    always_comb begin
      err_vec[i] = 1'b0;
      case (state)
        ST_IDLE: err_vec[i] = tail;
        ST_WAIT: err_vec[i] = head | tail;
        ST_HOLD: err_vec[i] = head & ~tail;
        default: err_vec[i] = 1'b0;
      endcase
    end

    assign req[i]            = (state == ST_WAIT);
    assign vc_route_valid[i] = (state == ST_HOLD);
    assign vc_next_addr[ASL +: ROUTER_ADDR_WIDTH]              = addr_q;
    assign dest_all[i*DEST_INFO_WIDTH +: DEST_INFO_WIDTH]      = dest_q;
    assign lar_all[i*LAR_INFO_WIDTH +: LAR_INFO_WIDTH]         = lar_q;
  end

  // --------------------------------------------------------------------------
  // Round-robin arbiter: first waiting VC at or after the pointer wins
  // --------------------------------------------------------------------------
  // Rotating priority search starting from rr_ptr, at most one grant
  always_comb begin
    int   idx;
    logic found;
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    for (int off = 0; off < NUM_VCS; off++) begin
      idx = int'(rr_ptr) + off;
      if (idx >= NUM_VCS) begin
        idx = idx - NUM_VCS;
      end
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = idx[PTR_W-1:0];
      end
    end
  end

  if (NUM_VCS > 1) begin : g_rr_ptr
    // Pointer moves to the VC after the one just granted, holds otherwise
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        rr_ptr <= '0;
      end else if (|grant) begin
        if (grant_idx == PTR_W'(NUM_VCS - 1)) begin
          rr_ptr <= '0;
        end else begin
          rr_ptr <= grant_idx + 1'b1;
        end
      end
    end
  end else begin : g_rr_single
    // A single VC is granted directly whenever it waits
    assign rr_ptr = '0;
  end

  // --------------------------------------------------------------------------
  // Shared-unit drive: one-hot mux of the granted VC's latched info
  // --------------------------------------------------------------------------
  // OR-reduce across the one-hot grant so no-grant yields all zeros
  always_comb begin
    shu_dest_info = '0;
    shu_lar_info  = '0;
    for (int i = 0; i < NUM_VCS; i++) begin
      if (grant[i]) begin
        shu_dest_info = shu_dest_info | dest_all[i*DEST_INFO_WIDTH +: DEST_INFO_WIDTH];
        shu_lar_info  = shu_lar_info  | lar_all[i*LAR_INFO_WIDTH +: LAR_INFO_WIDTH];
      end
    end
  end

  assign vc_grant  = grant;
  assign shu_valid = |grant;

  // Sticky protocol-violation flag, cleared only by reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_proto <= 1'b0;
    end else if (|err_vec) begin
      err_proto <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rtr_next_hop_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_rtr_next_hop_sched
// Brief    : Scoreboard bench for rtr_next_hop_sched. Stimulus pushes the
//            expected grant (VC, info, returned address) into a queue; a
//            negedge monitor pops on every shared-unit access and checks the
//            grant, the driven info and the captured route one cycle later.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rtr_next_hop_sched;

  localparam int NV = 4;
  localparam int DW = 17;
  localparam int LW = 4;
  localparam int AW = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [NV-1:0]     vc_head_valid = '0;
  logic [NV*DW-1:0]  vc_dest_info = '0;
  logic [NV*LW-1:0]  vc_lar_info = '0;
  logic [NV-1:0]     vc_tail_done = '0;
  logic              shu_valid;
  logic [DW-1:0]     shu_dest_info;
  logic [LW-1:0]     shu_lar_info;
  logic [AW-1:0]     shu_next_addr;
  logic [NV-1:0]     vc_route_valid;
  logic [NV*AW-1:0]  vc_next_addr;
  logic [NV-1:0]     vc_grant;
  logic              err_proto;

  rtr_next_hop_sched #(
    .NUM_VCS(NV), .DEST_INFO_WIDTH(DW), .LAR_INFO_WIDTH(LW), .ROUTER_ADDR_WIDTH(AW)
  ) dut (
    .clk(clk), .reset(reset),
    .vc_head_valid(vc_head_valid), .vc_dest_info(vc_dest_info),
    .vc_lar_info(vc_lar_info), .vc_tail_done(vc_tail_done),
    .shu_valid(shu_valid), .shu_dest_info(shu_dest_info),
    .shu_lar_info(shu_lar_info), .shu_next_addr(shu_next_addr),
    .vc_route_valid(vc_route_valid), .vc_next_addr(vc_next_addr),
    .vc_grant(vc_grant), .err_proto(err_proto)
  );

  always #5 clk = ~clk;

  // Shared unit stand-in: next address = low nibble of dest_info XOR lar_info
  assign shu_next_addr = shu_dest_info[3:0] ^ shu_lar_info;

  typedef struct {
    int          vc;
    logic [DW-1:0] dest;
    logic [LW-1:0] lar;
    logic [AW-1:0] addr;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int k, input logic [DW-1:0] d, input logic [LW-1:0] l);
    vc_dest_info[(NV-1-k)*DW +: DW] = d;
    vc_lar_info[(NV-1-k)*LW +: LW]  = l;
  endtask

  task automatic expect_grant(input int k, input logic [DW-1:0] d,
                              input logic [LW-1:0] l, input logic [AW-1:0] a);
    exp_t e;
    e.vc = k; e.dest = d; e.lar = l; e.addr = a;
    exp_q.push_back(e);
  endtask

  task automatic pulse(input logic [NV-1:0] h, input logic [NV-1:0] t);
    vc_head_valid = h;
    vc_tail_done  = t;
    tick();
    vc_head_valid = '0;
    vc_tail_done  = '0;
  endtask

  // Monitor: check last cycle's capture, then the current grant
  logic          cap_pend = 1'b0;
  int            cap_vc   = 0;
  logic [AW-1:0] cap_addr = '0;

  always @(negedge clk) begin
    exp_t          e;
    logic [NV-1:0] oh;
    logic [AW-1:0] sl;
    if (cap_pend && !reset) begin
      sl = vc_next_addr[(NV-1-cap_vc)*AW +: AW];
      chk("route_valid_rise", 32'(vc_route_valid[cap_vc]), 32'd1);
      chk("next_addr_capture", 32'(sl), 32'(cap_addr));
    end
    cap_pend = 1'b0;
    if (!reset && shu_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_grant", 32'(vc_grant), 32'd0);
      end else begin
        e  = exp_q.pop_front();
        oh = NV'(1) << e.vc;
        chk("grant_onehot", 32'(vc_grant), 32'(oh));
        chk("shu_dest_info", 32'(shu_dest_info), 32'(e.dest));
        chk("shu_lar_info", 32'(shu_lar_info), 32'(e.lar));
        cap_pend = 1'b1;
        cap_vc   = e.vc;
        cap_addr = e.addr;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // ---------------- reset state ----------------
    #3;
    chk("rst_route_valid", 32'(vc_route_valid), 32'd0);
    chk("rst_grant", 32'(vc_grant), 32'd0);
    chk("rst_shu_valid", 32'(shu_valid), 32'd0);
    chk("rst_shu_dest", 32'(shu_dest_info), 32'd0);
    chk("rst_next_addr", 32'(vc_next_addr), 32'd0);
    chk("rst_err", 32'(err_proto), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    tick();

    // ---------------- single VC0: lar 3 -> addr 5 ----------------
    load(0, 17'h12346, 4'h3);
    expect_grant(0, 17'h12346, 4'h3, 4'h5);
    pulse(4'b0001, 4'b0000);
    repeat (4) tick();
    pulse(4'b0000, 4'b0001);
    @(negedge clk);
    chk("t1_route_drop", 32'(vc_route_valid[0]), 32'd0);
    chk("t1_addr_retained", 32'(vc_next_addr[15:12]), 32'h5);

    // ---------------- VC3 alone, moves pointer back to VC0 ----------------
    load(3, 17'h0ABC1, 4'h8);
    expect_grant(3, 17'h0ABC1, 4'h8, 4'h9);
    pulse(4'b1000, 4'b0000);
    repeat (2) tick();
    pulse(4'b0000, 4'b1000);

    // ---------------- all four VCs at once, pointer at 0 ----------------
    load(0, 17'h10010, 4'h1); expect_grant(0, 17'h10010, 4'h1, 4'h1);
    load(1, 17'h00021, 4'h2); expect_grant(1, 17'h00021, 4'h2, 4'h3);
    load(2, 17'h00032, 4'h4); expect_grant(2, 17'h00032, 4'h4, 4'h6);
    load(3, 17'h1FFF3, 4'h8); expect_grant(3, 17'h1FFF3, 4'h8, 4'hB);
    pulse(4'b1111, 4'b0000);
    for (int j = 0; j < 5; j++) begin
      logic [NV-1:0] m;
      m = NV'((1 << j) - 1);
      @(negedge clk);
      chk("all4_route_stagger", 32'(vc_route_valid), 32'(m));
      if (j < 4) tick();
    end
    pulse(4'b0000, 4'b1111);

    // ---------------- fairness: VC1 and VC3 alternate ----------------
    load(1, 17'h00105, 4'h5); expect_grant(1, 17'h00105, 4'h5, 4'h0);
    load(3, 17'h00207, 4'h1); expect_grant(3, 17'h00207, 4'h1, 4'h6);
    pulse(4'b1010, 4'b0000);
    tick();
    load(1, 17'h0030F, 4'h2); expect_grant(1, 17'h0030F, 4'h2, 4'hD);
    pulse(4'b0010, 4'b0010);
    load(3, 17'h00408, 4'h3); expect_grant(3, 17'h00408, 4'h3, 4'hB);
    pulse(4'b1000, 4'b1000);
    load(1, 17'h0050A, 4'h6); expect_grant(1, 17'h0050A, 4'h6, 4'hC);
    pulse(4'b0010, 4'b0010);
    load(3, 17'h00604, 4'h7); expect_grant(3, 17'h00604, 4'h7, 4'h3);
    pulse(4'b1000, 4'b1000);
    tick();
    pulse(4'b0000, 4'b1010);

    // ---------------- back-to-back packets on VC2 ----------------
    load(2, 17'h0070C, 4'h1); expect_grant(2, 17'h0070C, 4'h1, 4'hD);
    pulse(4'b0100, 4'b0000);
    repeat (3) tick();
    load(2, 17'h00803, 4'h5); expect_grant(2, 17'h00803, 4'h5, 4'h6);
    pulse(4'b0100, 4'b0100);
    @(negedge clk);
    chk("b2b_route_low", 32'(vc_route_valid[2]), 32'd0);
    repeat (2) tick();
    pulse(4'b0000, 4'b0100);

    // ---------------- protocol error: head on VC0 during WAIT ----------------
    @(negedge clk);
    chk("err_clear_before", 32'(err_proto), 32'd0);
    load(0, 17'h00909, 4'h9); expect_grant(0, 17'h00909, 4'h9, 4'h0);
    pulse(4'b0001, 4'b0000);
    load(0, 17'h0AAAA, 4'h5);
    pulse(4'b0001, 4'b0000);
    @(negedge clk);
    chk("err_set", 32'(err_proto), 32'd1);
    repeat (3) tick();
    @(negedge clk);
    chk("err_sticky", 32'(err_proto), 32'd1);

    // ---------------- async reset with VC0 HOLD, VC1 WAIT ----------------
    tick();
    load(1, 17'h00B0E, 4'h4);
    pulse(4'b0010, 4'b0000);
    #2 reset = 1'b1;
    #1;
    chk("arst_route_valid", 32'(vc_route_valid), 32'd0);
    chk("arst_grant", 32'(vc_grant), 32'd0);
    chk("arst_shu_valid", 32'(shu_valid), 32'd0);
    chk("arst_shu_dest", 32'(shu_dest_info), 32'd0);
    chk("arst_shu_lar", 32'(shu_lar_info), 32'd0);
    chk("arst_next_addr", 32'(vc_next_addr), 32'd0);
    chk("arst_err", 32'(err_proto), 32'd0);
    @(posedge clk);
    @(negedge clk) reset = 1'b0;
    for (int j = 0; j < 3; j++) begin
      tick();
      @(negedge clk);
      chk("post_rst_no_grant", 32'(vc_grant), 32'd0);
      chk("post_rst_no_route", 32'(vc_route_valid), 32'd0);
    end

    // ---------------- fresh request after reset ----------------
    expect_grant(1, 17'h00B0E, 4'h4, 4'hA);
    pulse(4'b0010, 4'b0000);
    repeat (2) tick();
    pulse(4'b0000, 4'b0010);

    repeat (3) tick();
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
